ysyx_25030093_sram: RTL and testbench

YSYX_25030093_SRAM -- requirements
Module: ysyx_25030093_sram

---
 rtl/ysyx_25030093_sram.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_25030093_sram.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_sram.sv
// ysyx_25030093_sram: single-port 32-bit word memory behind a valid/ready
// request channel and a valid/ready response channel. One request is in
// flight at a time; the response appears a fixed LATENCY cycles after the
// request is accepted. Out-of-range or misaligned accesses return an error
// and never touch the array.
module ysyx_25030093_sram #(
    parameter int          ADDR_BITS = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORDS = 1 << ADDR_BITS;

    state_t state_r;
    state_t state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;

    logic [31:0] addr_r;
    logic        wen_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;

    logic [31:0] rdata_r;
    logic        err_r;

    logic [31:0] mem_r [WORDS];

    logic                 accept_s;
    logic                 commit_s;
    logic [31:0]          acc_addr_s;
    logic                 acc_wen_s;
    logic [31:0]          acc_wdata_s;
    logic [3:0]           acc_wstrb_s;
    logic                 acc_fault_s;
    logic [ADDR_BITS-1:0] acc_index_s;

    // Misaligned, below the base, or at/after the end of the window.
    function automatic logic addr_fault(input logic [31:0] a);
        logic [32:0] limit;
        limit = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_BITS + 2));
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= limit);
    endfunction

    // Replace only the bytes selected by the strobe.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign accept_s = req_valid && (state_r == ST_IDLE);
    // The access happens on whichever edge moves the FSM into RESP.
    assign commit_s = (state_s == ST_RESP) && (state_r != ST_RESP);

    // With LATENCY=1 the access coincides with acceptance, so it must use the
    // live request fields rather than the not-yet-latched copies.
    always_comb begin
        acc_addr_s  = addr_r;
        acc_wen_s   = wen_r;
        acc_wdata_s = wdata_r;
        acc_wstrb_s = wstrb_r;
        if (state_r == ST_IDLE) begin
            acc_addr_s  = req_addr;
            acc_wen_s   = req_wen;
            acc_wdata_s = req_wdata;
            acc_wstrb_s = req_wstrb;
        end else begin
            acc_addr_s  = addr_r;
            acc_wen_s   = wen_r;
            acc_wdata_s = wdata_r;
            acc_wstrb_s = wstrb_r;
        end
    end

    assign acc_fault_s = addr_fault(acc_addr_s);
    assign acc_index_s = ADDR_BITS'((acc_addr_s - BASE_ADDR) >> 2);

    // Next-state and latency counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_s = ST_RESP;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = ST_RESP;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Latch the request so later changes on req_* cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 32'd0;
            wen_r   <= 1'b0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wen_r   <= req_wen;
            wdata_r <= req_wdata;
            wstrb_r <= req_wstrb;
        end
    end

    // Capture the response word (pre-write value for writes) on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else if (commit_s) begin
            if (acc_fault_s) begin
                rdata_r <= 32'd0;
                err_r   <= 1'b1;
            end else begin
                rdata_r <= mem_r[acc_index_s];
                err_r   <= 1'b0;
            end
        end
    end

    // Array write; contents are not reset and a reset edge blocks the commit.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && acc_wen_s && !acc_fault_s) begin
            mem_r[acc_index_s] <= byte_merge(mem_r[acc_index_s], acc_wdata_s, acc_wstrb_s);
        end
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = (state_r == ST_RESP);
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: tb/tb_ysyx_25030093_sram.sv
// Testbench for ysyx_25030093_sram: three instances (LATENCY 2, 4 and 1) on a
// shared clock. The driver pushes the expected response when it issues a
// request; an independent monitor pops and compares on every response handshake.
module tb_ysyx_25030093_sram;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    logic        clk;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        req_wen    [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_wstrb  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    exp_t exp_q [3][$];
    int   n_chk;
    int   n_err;

    localparam logic [31:0] L1_DATA [8] = '{
        32'h0000_0001, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
        32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'hFFFF_0000, 32'h8000_0001
    };
    localparam logic [31:0] FAULT_ADDR [3] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_0002};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_25030093_sram #(
            .ADDR_BITS(12),
            .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 4 : 1)),
            .BASE_ADDR(32'h8000_0000)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_wen   (req_wen[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
    endfunction

    task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %h expected %h", i, nm, act, exp);
        end
    endtask

    // Monitor: compare each response handshake against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dut%0d unexpected_resp: got rdata %h err %b, expected no response",
                             i, resp_rdata[i], resp_err[i]);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    check(i, "resp_err", 32'(resp_err[i]), 32'(e.err));
                    if (e.chk_data) begin
                        check(i, "resp_rdata", resp_rdata[i], e.rdata);
                    end
                end
            end
        end
    end

    // Issue one request, check its latency and the return to IDLE after handshake.
    task automatic do_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] er, input logic ee, input logic cd);
        int c;
        check(i, "req_ready_before", 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        req_wen[i]   = w;
        req_wdata[i] = d;
        req_wstrb[i] = s;
        exp_q[i].push_back('{rdata: er, err: ee, chk_data: cd});
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        req_addr[i]  = ~a;
        req_wen[i]   = ~w;
        req_wdata[i] = ~d;
        req_wstrb[i] = ~s;
        c = 1;
        while (resp_valid[i] !== 1'b1 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(i, "latency", 32'(c), 32'(lat_of(i)));
        @(posedge clk);
        #1;
        check(i, "req_ready_after_hs", 32'(req_ready[i]), 32'd1);
        check(i, "resp_valid_after_hs", 32'(resp_valid[i]), 32'd0);
    endtask

    initial begin
        int c;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i]        = 1'b1;
            req_valid[i]  = 1'b0;
            req_addr[i]   = 32'd0;
            req_wen[i]    = 1'b0;
            req_wdata[i]  = 32'd0;
            req_wstrb[i]  = 4'd0;
            resp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            check(i, "reset_req_ready", 32'(req_ready[i]), 32'd1);
            check(i, "reset_resp_valid", 32'(resp_valid[i]), 32'd0);
            check(i, "reset_resp_rdata", resp_rdata[i], 32'd0);
            check(i, "reset_resp_err", 32'(resp_err[i]), 32'd0);
        end

        // LATENCY=2: full write, read, partial write, zero-strobe write.
        do_req(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0);
        do_req(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(0, 32'h8000_0010, 1'b1, 32'h0000_AA00, 4'h2, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_AAEF, 1'b0, 1'b1);
        do_req(0, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'h0, 32'hDEAD_AAEF, 1'b0, 1'b1);
        do_req(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_AAEF, 1'b0, 1'b1);
        do_req(0, 32'h8000_0000, 1'b1, 32'h0123_4567, 4'hF, 32'd0, 1'b0, 1'b0);
        do_req(0, 32'h8000_3FFC, 1'b1, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 1'b0);
        do_req(0, 32'h8000_3FFC, 1'b0, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

        // Faults: each address read and written; nothing may change.
        for (int k = 0; k < 3; k++) begin
            do_req(0, FAULT_ADDR[k], 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1);
            do_req(0, FAULT_ADDR[k], 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b1);
        end
        do_req(0, 32'h8000_0000, 1'b0, 32'd0, 4'h0, 32'h0123_4567, 1'b0, 1'b1);
        do_req(0, 32'h8000_3FFC, 1'b0, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        do_req(0, 32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_AAEF, 1'b0, 1'b1);

        // Back-pressure: resp_ready low for 5 cycles with a competing request.
        resp_ready[0] = 1'b0;
        req_valid[0]  = 1'b1;
        req_addr[0]   = 32'h8000_0010;
        req_wen[0]    = 1'b0;
        req_wstrb[0]  = 4'h0;
        exp_q[0].push_back('{rdata: 32'hDEAD_AAEF, err: 1'b0, chk_data: 1'b1});
        @(posedge clk);
        #1;
        req_addr[0]  = 32'h8000_0000;
        req_wen[0]   = 1'b1;
        req_wdata[0] = 32'h5555_5555;
        req_wstrb[0] = 4'hF;
        c = 1;
        while (resp_valid[0] !== 1'b1 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(0, "hold_latency", 32'(c), 32'd2);
        for (int k = 0; k < 5; k++) begin
            check(0, "hold_resp_valid", 32'(resp_valid[0]), 32'd1);
            check(0, "hold_resp_rdata", resp_rdata[0], 32'hDEAD_AAEF);
            check(0, "hold_resp_err", 32'(resp_err[0]), 32'd0);
            check(0, "hold_req_ready", 32'(req_ready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check(0, "hold_release_req_ready", 32'(req_ready[0]), 32'd1);
        check(0, "hold_release_resp_valid", 32'(resp_valid[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        do_req(0, 32'h8000_0000, 1'b0, 32'd0, 4'h0, 32'h0123_4567, 1'b0, 1'b1);

        // LATENCY=4: reset while a write is waiting drops the write.
        do_req(1, 32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, 32'd0, 1'b0, 1'b0);
        do_req(1, 32'h8000_0020, 1'b0, 32'd0, 4'h0, 32'h1122_3344, 1'b0, 1'b1);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0020;
        req_wen[1]   = 1'b1;
        req_wdata[1] = 32'h5566_7788;
        req_wstrb[1] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check(1, "wait_req_ready", 32'(req_ready[1]), 32'd0);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        check(1, "rst_wait_req_ready", 32'(req_ready[1]), 32'd1);
        check(1, "rst_wait_resp_valid", 32'(resp_valid[1]), 32'd0);
        check(1, "rst_wait_resp_rdata", resp_rdata[1], 32'd0);
        repeat (6) @(posedge clk);
        #1;
        do_req(1, 32'h8000_0020, 1'b0, 32'd0, 4'h0, 32'h1122_3344, 1'b0, 1'b1);

        // LATENCY=1: eight back-to-back writes then eight back-to-back reads.
        for (int k = 0; k < 8; k++) begin
            do_req(2, 32'h8000_0100 + 32'(4 * k), 1'b1, L1_DATA[k], 4'hF, 32'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            do_req(2, 32'h8000_0100 + 32'(4 * k), 1'b0, 32'd0, 4'h0, L1_DATA[k], 1'b0, 1'b1);
        end

        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check(i, "queue_drained", 32'(exp_q[i].size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
